// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: controller state
// encoding and the default operand widths.
package div_pkg;

    // Default divisor/remainder width; dividend and quotient are twice this.
    localparam int DIV_N  = 4;
    localparam int DIV_DW = 2 * DIV_N;          // dividend / quotient width
    localparam int DIV_RW = DIV_N + 1;          // partial remainder width
    localparam int DIV_CW = $clog2(2 * DIV_N);  // iteration counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: compare the shifted partial remainder
// against the divisor, subtract when it fits, and report the quotient bit.
module div_step #(
    parameter int N = 4
) (
    input  logic [N:0]   i_shifted,
    input  logic [N-1:0] i_divisor,
    output logic [N:0]   o_rem,
    output logic         o_qbit
);

    logic [N:0] w_dvs_ext;
    logic [N:0] w_diff;

    assign w_dvs_ext = {1'b0, i_divisor};
    assign w_diff    = i_shifted - w_dvs_ext;

    // Restore (keep the shifted value) when the divisor does not fit.
    always_comb begin
        o_qbit = (i_shifted >= w_dvs_ext);
        o_rem  = o_qbit ? w_diff : i_shifted;
    end

endmodule

// File: rtl/div8u4_seq.sv
// Sequential unsigned divider: 2N-bit dividend by N-bit divisor, one quotient
// bit per cycle, MSB first, with valid/ready handshakes on both sides.
// A zero divisor runs the same 2N iterations; the compare always succeeds so
// the quotient comes out all-ones, and the remainder is forced to zero.
module div8u4_seq
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int DW = 2 * N;
    localparam int RW = N + 1;
    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0] LAST_ITER = CW'(2 * N - 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_dvd;      // remaining dividend bits shift out, quotient bits shift in
    logic [N-1:0]    r_dvs;
    logic [RW-1:0]   r_prem;
    logic [DW-1:0]   r_quo;
    logic [N-1:0]    r_rem;
    logic            r_dbz;

    logic [RW-1:0]   w_shifted;
    logic [RW-1:0]   w_next_rem;
    logic            w_qbit;
    logic            w_last;
    logic            w_dbz;
    logic            w_accept;

    // Handshake flags come straight from the state register only.
    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_last    = (r_cnt == LAST_ITER);
    assign w_dbz     = (r_dvs == '0);
    // Partial remainder always fits in N bits after a step, so dropping the
    // top bit while shifting in the next dividend bit loses nothing.
    assign w_shifted = RW'({r_prem, r_dvd[DW-1]});

    div_step #(
        .N (N)
    ) u_step (
        .i_shifted (w_shifted),
        .i_divisor (r_dvs),
        .o_rem     (w_next_rem),
        .o_qbit    (w_qbit)
    );

    // Controller: accept in IDLE, iterate 2N times in BUSY, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state <= BUSY;
                        r_cnt   <= '0;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Working registers: load operands on acceptance, shift once per BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_prem <= '0;
        end else if (w_accept) begin
            r_dvd  <= dividend;
            r_dvs  <= divisor;
            r_prem <= '0;
        end else if (r_state == BUSY) begin
            r_dvd  <= {r_dvd[DW-2:0], w_qbit};
            r_prem <= w_next_rem;
        end
    end

    // Result registers: capture on the final iteration, then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dbz <= 1'b0;
        end else if ((r_state == BUSY) && w_last) begin
            r_quo <= {r_dvd[DW-2:0], w_qbit};
            r_rem <= w_dbz ? '0 : N'(w_next_rem);
            r_dbz <= w_dbz;
        end
    end

endmodule

// File: tb/tb_div8u4_seq.sv
// Bench for div8u4_seq: directed scenarios followed by a randomly ordered
// sweep of every operand pair under random consumer backpressure.
module tb_div8u4_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int failures = 0;
    int valid_seen = 0;

    always #5 clk = ~clk;

    div8u4_seq #(.N(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Running count of cycles with out_valid high, sampled mid-cycle.
    always @(negedge clk) begin
        if (out_valid === 1'b1) valid_seen = valid_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {div_by_zero, quotient, remainder} from plain arithmetic.
    function automatic logic [31:0] model(input logic [7:0] a, input logic [3:0] b);
        int q;
        int r;
        if (b == 0) return {19'd0, 1'b1, 8'hFF, 4'h0};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {19'd0, 1'b0, 8'(q), 4'(r)};
    endfunction

    function automatic logic [31:0] observed();
        return {19'd0, div_by_zero, quotient, remainder};
    endfunction

    // Wait (bounded) for in_ready at a falling edge, offer operands, let the
    // next rising edge accept them.
    task automatic send(input logic [7:0] a, input logic [3:0] b);
        int k;
        k = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("send_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Cycles counted from the accepting edge; cycle 1 is the one right after it.
    task automatic wait_out(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [7:0] a, input logic [3:0] b);
        int lat;
        send(a, b);
        wait_out(lat);
        chk({tag, "_latency"}, lat, 32'd9);
        chk({tag, "_result"}, observed(), model(a, b));
    endtask

    initial begin
        int lat;
        int seen0;
        logic [31:0] mult;
        logic [31:0] off;
        logic [11:0] idx;

        // Reset state while rst_n is held low.
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient", {24'd0, quotient}, 32'd0);
        chk("rst_remainder", {28'd0, remainder}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 200/7 = 28 r4
        run_one("d200_7", 8'd200, 4'd7);
        chk("d200_7_q", {24'd0, quotient}, 32'd28);
        chk("d200_7_r", {28'd0, remainder}, 32'd4);
        chk("done_in_ready", {31'd0, in_ready}, 32'd0);
        consume();
        @(negedge clk);
        chk("after_consume_out_valid", {31'd0, out_valid}, 32'd0);
        chk("after_consume_in_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back 255/1 then 255/15.
        run_one("d255_1", 8'd255, 4'd1);
        chk("d255_1_q", {24'd0, quotient}, 32'd255);
        consume();
        run_one("d255_15", 8'd255, 4'd15);
        chk("d255_15_q", {24'd0, quotient}, 32'd17);
        consume();

        // Zero dividend and zero divisor.
        run_one("d0_5", 8'd0, 4'd5);
        consume();
        run_one("d9_0", 8'd9, 4'd0);
        chk("d9_0_full", observed(), {19'd0, 1'b1, 8'hFF, 4'h0});
        consume();

        // Backpressure in DONE with new operands offered: all ignored.
        run_one("bp77_3", 8'd77, 4'd3);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold", observed(), model(8'd77, 4'd3));
        end
        consume();
        @(negedge clk);
        chk("bp_no_accept", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of 123/6: abort, nothing ever presented.
        send(8'd123, 4'd6);
        repeat (4) @(negedge clk);
        seen0 = valid_seen;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_quotient", {24'd0, quotient}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_never_valid", valid_seen - seen0, 32'd0);

        // Operands offered on the very first edge after reset release.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        dividend = 8'd123;
        divisor  = 4'd6;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out(lat);
        chk("first_edge_latency", lat, 32'd9);
        chk("first_edge_result", observed(), {19'd0, 1'b0, 8'd20, 4'd3});
        consume();

        // Every operand pair, visited in a random order, random backpressure.
        mult = $urandom | 32'd1;
        off  = $urandom;
        for (int i = 0; i < 4096; i++) begin
            idx = 12'(i * mult + off);
            run_one("sweep", idx[11:4], idx[3:0]);
            for (int h = $urandom_range(0, 3); h > 0; h--) begin
                in_valid = 1'($urandom);
                dividend = 8'($urandom);
                divisor  = 4'($urandom);
                @(negedge clk);
            end
            chk("sweep_held", observed(), model(idx[11:4], idx[3:0]));
            consume();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
